chirp_band_sequencer: RTL and testbench

CHIRP_BAND_SEQUENCER -- requirements
Module: chirp_band_sequencer

---
 rtl/chirp_band_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_chirp_band_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_band_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chirp_band_sequencer
//  Purpose  : Steps an external band selector through a captured band mask.
//             Each selected band is dwelled on for a fixed number of cycles.
//             Complete passes through the mask (sweeps) are counted, and the
//             sequence can run for a set number of sweeps or indefinitely.
//  Ports    : clk, reset_n (sync, active-low)
//             start/abort            - sequence control
//             cfg_bands/dwell/sweeps - configuration, captured on accepted start
//             sel_latch_input, sel_update_band, sel_to_use_bands -> selector
//             sel_band, sel_ready    <- selector
//             band, band_valid, sweep_count, busy, done, cfg_err - status
//  Revision : 1.0  initial release
// ============================================================================
module chirp_band_sequencer #(
    parameter int MAX_BANDS   = 64,
    parameter int BAND_WIDTH  = 6,
    parameter int DWELL_WIDTH = 16,
    parameter int SWEEP_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [MAX_BANDS-1:0]   cfg_bands,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [SWEEP_WIDTH-1:0] cfg_sweeps,
    output logic                   sel_latch_input,
    output logic                   sel_update_band,
    output logic [MAX_BANDS-1:0]   sel_to_use_bands,
    input  logic [BAND_WIDTH-1:0]  sel_band,
    input  logic                   sel_ready,
    output logic [BAND_WIDTH-1:0]  band,
    output logic                   band_valid,
    output logic [SWEEP_WIDTH-1:0] sweep_count,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_SEL = 3'd2,
        ST_DWELL    = 3'd3,
        ST_STEP     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [MAX_BANDS-1:0]   r_mask;
    logic [DWELL_WIDTH-1:0] r_dwell_cfg;
    logic [SWEEP_WIDTH-1:0] r_sweeps_cfg;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;
    logic [BAND_WIDTH-1:0]  r_band;
    logic [SWEEP_WIDTH-1:0] r_sweep_count;
    logic                   r_cfg_err;
    // First WAIT_SEL cycle: the selector's ready flag still reflects the
    // previous request, so it must not be trusted yet.
    logic                   r_wait_first;
    // Remembers whether the current WAIT_SEL was entered from STEP (wrap
    // detection applies) or from LOAD (first band of the sequence).
    logic                   r_after_step;

    logic                   w_accept;
    logic                   w_reject;
    logic                   w_take_band;
    logic                   w_wrap;
    logic [SWEEP_WIDTH-1:0] w_sweep_inc;

    // Saturating increment: continuous runs park at all-ones.
    assign w_sweep_inc = (r_sweep_count == '1) ? r_sweep_count
                                               : r_sweep_count + SWEEP_WIDTH'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_take_band  = 1'b0;
        w_wrap       = 1'b0;

        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bands != '0) begin
                            w_accept     = 1'b1;
                            w_state_next = ST_LOAD;
                        end else begin
                            w_reject     = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    w_state_next = ST_WAIT_SEL;
                end
                ST_WAIT_SEL: begin
                    if (!r_wait_first && sel_ready) begin
                        // A new band at or below the current one means the
                        // selector has gone round the mask once more.
                        if (r_after_step && (sel_band <= r_band)) begin
                            w_wrap = 1'b1;
                        end
                        if (w_wrap && (r_sweeps_cfg != '0) &&
                            (w_sweep_inc == r_sweeps_cfg)) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_take_band  = 1'b1;
                            w_state_next = ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    if (r_dwell_cnt == DWELL_WIDTH'(1)) begin
                        w_state_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    w_state_next = ST_WAIT_SEL;
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask        <= '0;
            r_dwell_cfg   <= '0;
            r_sweeps_cfg  <= '0;
            r_dwell_cnt   <= '0;
            r_band        <= '0;
            r_sweep_count <= '0;
            r_cfg_err     <= 1'b0;
            r_wait_first  <= 1'b0;
            r_after_step  <= 1'b0;
        end else begin
            r_cfg_err    <= w_reject;
            r_wait_first <= (r_state == ST_LOAD) || (r_state == ST_STEP);

            if (r_state == ST_LOAD) begin
                r_after_step <= 1'b0;
            end else if (r_state == ST_STEP) begin
                r_after_step <= 1'b1;
            end

            if (w_accept) begin
                r_mask        <= cfg_bands;
                // A zero dwell still gives each band one valid cycle.
                r_dwell_cfg   <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
                r_sweeps_cfg  <= cfg_sweeps;
                r_sweep_count <= '0;
            end

            if (w_wrap) begin
                r_sweep_count <= w_sweep_inc;
            end

            if (w_take_band) begin
                r_band      <= sel_band;
                r_dwell_cnt <= r_dwell_cfg;
            end else if (r_state == ST_DWELL) begin
                r_dwell_cnt <= r_dwell_cnt - DWELL_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sel_latch_input  = (r_state == ST_LOAD);
    assign sel_update_band  = (r_state == ST_STEP);
    assign sel_to_use_bands = r_mask;
    assign band             = r_band;
    assign band_valid       = (r_state == ST_DWELL);
    assign sweep_count      = r_sweep_count;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);
    assign cfg_err          = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_chirp_band_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chirp_band_sequencer
//  Purpose  : Self-checking bench for chirp_band_sequencer. A behavioural
//             band selector answers the DUT; a timeline model builds the
//             expected per-cycle outputs from band lists and fixed latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chirp_band_sequencer;

    localparam int MB = 64;
    localparam int BW = 6;
    localparam int DW = 16;
    localparam int SW = 8;
    localparam int N  = 8192;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [MB-1:0] cfg_bands;
    logic [DW-1:0] cfg_dwell;
    logic [SW-1:0] cfg_sweeps;
    logic          sel_latch_input;
    logic          sel_update_band;
    logic [MB-1:0] sel_to_use_bands;
    logic [BW-1:0] sel_band  = '0;
    logic          sel_ready = 1'b1;
    logic [BW-1:0] band;
    logic          band_valid;
    logic [SW-1:0] sweep_count;
    logic          busy;
    logic          done;
    logic          cfg_err;

    chirp_band_sequencer #(
        .MAX_BANDS   (MB),
        .BAND_WIDTH  (BW),
        .DWELL_WIDTH (DW),
        .SWEEP_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .cfg_bands        (cfg_bands),
        .cfg_dwell        (cfg_dwell),
        .cfg_sweeps       (cfg_sweeps),
        .sel_latch_input  (sel_latch_input),
        .sel_update_band  (sel_update_band),
        .sel_to_use_bands (sel_to_use_bands),
        .sel_band         (sel_band),
        .sel_ready        (sel_ready),
        .band             (band),
        .band_valid       (band_valid),
        .sweep_count      (sweep_count),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural band selector: lowest set band after a latch, next set
    // band (cyclic) after an update. Ready lingers one cycle, then drops;
    // it returns 6 cycles after a latch and 4 after an update.
    // ------------------------------------------------------------------
    logic          lat_q = 1'b0;
    logic          upd_q = 1'b0;
    logic [MB-1:0] mask_q = '0;
    logic [MB-1:0] sm_mask = '0;
    int            sm_idx = 0;
    int            sm_delay = 0;

    always @(negedge clk) begin
        lat_q  = sel_latch_input;
        upd_q  = sel_update_band;
        mask_q = sel_to_use_bands;
    end

    always @(posedge clk) begin
        if (lat_q) begin
            sm_mask = mask_q;
            for (int i = MB - 1; i >= 0; i--) begin
                if (sm_mask[i]) sm_idx = i;
            end
            sm_delay = 5;
        end else if (upd_q) begin
            automatic bit found = 1'b0;
            automatic int nxt = sm_idx;
            for (int k = 1; k <= MB; k++) begin
                if (!found && sm_mask[(sm_idx + k) % MB]) begin
                    nxt   = (sm_idx + k) % MB;
                    found = 1'b1;
                end
            end
            sm_idx   = nxt;
            sm_delay = 3;
        end else if (sm_delay > 0) begin
            sm_delay--;
            sel_ready <= (sm_delay == 0);
            if (sm_delay == 0) sel_band <= BW'(sm_idx);
        end
    end

    // ------------------------------------------------------------------
    // Timeline model: expected outputs per cycle index
    // ------------------------------------------------------------------
    logic          exp_busy   [N];
    logic          exp_valid  [N];
    logic          exp_latch  [N];
    logic          exp_update [N];
    logic          exp_done   [N];
    logic          exp_err    [N];
    logic [BW-1:0] exp_band   [N];
    logic [SW-1:0] exp_sweep  [N];
    logic [MB-1:0] exp_mask   [N];

    task automatic fill_idle(input int from, input logic [BW-1:0] b, input logic [SW-1:0] s, input logic [MB-1:0] m);
        for (int c = from; c < N; c++) begin
            exp_busy[c]   = 1'b0;
            exp_valid[c]  = 1'b0;
            exp_latch[c]  = 1'b0;
            exp_update[c] = 1'b0;
            exp_done[c]   = 1'b0;
            exp_err[c]    = 1'b0;
            exp_band[c]   = b;
            exp_sweep[c]  = s;
            exp_mask[c]   = m;
        end
    endtask

    task automatic set_cyc(input int c, input logic v, input logic up, input logic dn,
                           input int b, input int s);
        exp_busy[c]   = 1'b1;
        exp_valid[c]  = v;
        exp_update[c] = up;
        exp_done[c]   = dn;
        exp_band[c]   = BW'(b);
        exp_sweep[c]  = SW'(s);
    endtask

    // Start accepted in cycle s: latch at s+1, first dwell at s+8, each
    // dwell of dd cycles is followed by a step cycle and the next dwell
    // (or done) five cycles after that step.
    task automatic plan(input int s, input logic [MB-1:0] m, input int d, input int sweeps);
        int bl[$];
        int dd, idx, nidx, c, sweep;
        for (int i = 0; i < MB; i++) if (m[i]) bl.push_back(i);
        dd = (d == 0) ? 1 : d;
        fill_idle(s + 1, exp_band[s], '0, m);
        for (int k = s + 1; k <= s + 7; k++) set_cyc(k, 1'b0, 1'b0, 1'b0, exp_band[s], 0);
        exp_latch[s + 1] = 1'b1;
        sweep = 0;
        idx   = 0;
        c     = s + 8;
        while (c + dd + 6 < N) begin
            for (int k = 0; k < dd; k++) set_cyc(c + k, 1'b1, 1'b0, 1'b0, bl[idx], sweep);
            set_cyc(c + dd, 1'b0, 1'b1, 1'b0, bl[idx], sweep);
            for (int k = 1; k <= 4; k++) set_cyc(c + dd + k, 1'b0, 1'b0, 1'b0, bl[idx], sweep);
            nidx = (idx + 1) % bl.size();
            if (nidx == 0 && sweep < 255) sweep++;
            if (nidx == 0 && sweeps != 0 && sweep == sweeps) begin
                set_cyc(c + dd + 5, 1'b0, 1'b0, 1'b1, bl[idx], sweep);
                fill_idle(c + dd + 6, BW'(bl[idx]), SW'(sweep), m);
                return;
            end
            idx = nidx;
            c   = c + dd + 5;
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    logic checking = 1'b0;

    always @(negedge clk) begin
        if (checking && cyc < N) begin
            chk("busy",        cyc, 64'(busy),             64'(exp_busy[cyc]));
            chk("band_valid",  cyc, 64'(band_valid),       64'(exp_valid[cyc]));
            chk("latch",       cyc, 64'(sel_latch_input),  64'(exp_latch[cyc]));
            chk("update",      cyc, 64'(sel_update_band),  64'(exp_update[cyc]));
            chk("done",        cyc, 64'(done),             64'(exp_done[cyc]));
            chk("cfg_err",     cyc, 64'(cfg_err),          64'(exp_err[cyc]));
            chk("band",        cyc, 64'(band),             64'(exp_band[cyc]));
            chk("sweep_count", cyc, 64'(sweep_count),      64'(exp_sweep[cyc]));
            chk("mask",        cyc, 64'(sel_to_use_bands), 64'(exp_mask[cyc]));
        end
    end

    int done_cnt  = 0;
    int done_cyc  = 0;
    int latch_cnt = 0;

    always @(negedge clk) begin
        if (checking) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sel_latch_input) latch_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic abort_now();
        abort = 1'b1;
        fill_idle(cyc + 1, exp_band[cyc], exp_sweep[cyc], exp_mask[cyc]);
        step(1);
        abort = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int s;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_bands  = '0;
        cfg_dwell  = '0;
        cfg_sweeps = '0;
        fill_idle(0, '0, '0, '0);
        step(2);
        checking = 1'b1;
        chk("reset_busy", cyc, 64'(busy), 64'd0);
        chk("reset_mask", cyc, 64'(sel_to_use_bands), 64'd0);
        step(1);
        reset_n = 1'b1;
        step(3);

        // Empty mask: rejected with a single cfg_err pulse
        latch_cnt = 0;
        s = cyc;
        start = 1'b1;
        exp_err[s + 1] = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("empty_mask_latch_count", cyc, 64'(latch_cnt), 64'd0);

        // Bands {2,5,7}, dwell 3, one sweep, start held throughout
        s = cyc;
        cfg_bands  = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 7);
        cfg_dwell  = 16'd3;
        cfg_sweeps = 8'd1;
        start      = 1'b1;
        done_cnt   = 0;
        latch_cnt  = 0;
        plan(s, cfg_bands, 3, 1);
        step(33);
        start = 1'b0;
        step(4);
        chk("three_band_done_count", cyc, 64'(done_cnt),   64'd1);
        chk("three_band_done_cycle", cyc, 64'(done_cyc - s), 64'd32);
        chk("three_band_final_band", cyc, 64'(band),        64'd7);
        chk("three_band_sweeps",     cyc, 64'(sweep_count), 64'd1);
        chk("three_band_latches",    cyc, 64'(latch_cnt),   64'd1);

        // Single band {4}, zero dwell, three sweeps
        s = cyc;
        cfg_bands  = 64'd1 << 4;
        cfg_dwell  = 16'd0;
        cfg_sweeps = 8'd3;
        start      = 1'b1;
        done_cnt   = 0;
        plan(s, cfg_bands, 0, 3);
        step(1);
        start = 1'b0;
        step(30);
        chk("one_band_done_count", cyc, 64'(done_cnt),     64'd1);
        chk("one_band_done_cycle", cyc, 64'(done_cyc - s), 64'd26);
        chk("one_band_final_band", cyc, 64'(band),         64'd4);
        chk("one_band_sweeps",     cyc, 64'(sweep_count),  64'd3);

        // Abort during DWELL
        s = cyc;
        cfg_bands  = (64'd1 << 1) | (64'd1 << 3);
        cfg_dwell  = 16'd5;
        cfg_sweeps = 8'd0;
        start      = 1'b1;
        done_cnt   = 0;
        plan(s, cfg_bands, 5, 0);
        step(1);
        start = 1'b0;
        step(9);
        abort_now();
        step(3);
        chk("abort_no_done", cyc, 64'(done_cnt), 64'd0);

        // Abort beats start in the same cycle
        latch_cnt = 0;
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        step(3);
        chk("abort_priority_latches", cyc, 64'(latch_cnt), 64'd0);

        // Fresh start after abort begins with a latch
        s = cyc;
        start = 1'b1;
        plan(s, cfg_bands, 5, 0);
        step(1);
        start = 1'b0;
        step(12);
        abort_now();
        step(2);
        chk("restart_latches", cyc, 64'(latch_cnt), 64'd1);

        // Reset during WAIT_SEL, then a normal run of two sweeps over {6,9}
        s = cyc;
        cfg_bands  = (64'd1 << 6) | (64'd1 << 9);
        cfg_dwell  = 16'd2;
        cfg_sweeps = 8'd2;
        start      = 1'b1;
        done_cnt   = 0;
        plan(s, cfg_bands, 2, 2);
        step(1);
        start = 1'b0;
        step(3);
        reset_n = 1'b0;
        fill_idle(cyc + 1, '0, '0, '0);
        step(1);
        reset_n = 1'b1;
        step(2);
        chk("reset_mid_no_done", cyc, 64'(done_cnt), 64'd0);
        s = cyc;
        start = 1'b1;
        plan(s, cfg_bands, 2, 2);
        step(1);
        start = 1'b0;
        step(40);
        chk("two_sweep_done_count", cyc, 64'(done_cnt),     64'd1);
        chk("two_sweep_done_cycle", cyc, 64'(done_cyc - s), 64'd36);

        // Continuous over {0,63}: sweep count saturates, no done
        s = cyc;
        cfg_bands  = (64'd1 << 0) | (64'd1 << 63);
        cfg_dwell  = 16'd1;
        cfg_sweeps = 8'd0;
        start      = 1'b1;
        done_cnt   = 0;
        plan(s, cfg_bands, 1, 0);
        step(1);
        start = 1'b0;
        step(3150);
        chk("continuous_saturated", cyc, 64'(sweep_count), 64'd255);
        chk("continuous_no_done",   cyc, 64'(done_cnt),    64'd0);
        abort_now();
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
